bus_width_decrease: RTL and testbench

BUS_WIDTH_DECREASE -- requirements
Module: bus_width_decrease

---
 rtl/bus_width_decrease.sv | 162 ++++++++++++++++
 tb/tb_bus_width_decrease.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bus_width_decrease.sv
// bus_width_decrease
//   Splits each SIZE_IN-bit input word into RATIO = SIZE_IN/SIZE_OUT slices of
//   SIZE_OUT bits and emits them least-significant slice first over a
//   valid/ready stream. Without back-pressure one slice leaves per cycle and
//   consecutive words follow each other with no bubble.
//
//   Configuration macro: BUS_WIDTH_DECREASE_DOUBLE_BUF_EN
//     undefined : single word register; ready_in is combinational and
//                 depends on ready_out (a new word loads on the last-slice edge).
//     defined   : an extra hold word register catches the next word while the
//                 active one drains; ready_in comes straight from a flop.
//
//   Ports
//     clk        in   rising-edge clock
//     reset_n    in   asynchronous active-low reset
//     valid_in   in   data_in holds a word to transfer
//     ready_in   out  block can accept a word this cycle
//     data_in    in   SIZE_IN-bit input word
//     valid_out  out  data_out holds a valid slice
//     ready_out  in   downstream accepts the slice this cycle
//     data_out   out  SIZE_OUT-bit output slice
module bus_width_decrease #(
    parameter int SIZE_IN  = 32,
    parameter int SIZE_OUT = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                valid_in,
    output logic                ready_in,
    input  logic [SIZE_IN-1:0]  data_in,
    output logic                valid_out,
    input  logic                ready_out,
    output logic [SIZE_OUT-1:0] data_out
);

    localparam int RATIO = SIZE_IN / SIZE_OUT;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    generate
        if ((SIZE_IN % SIZE_OUT) != 0 || RATIO < 2) begin : g_bad_cfg
            $error("bus_width_decrease: SIZE_IN must be an integer multiple (>=2) of SIZE_OUT");
        end
    endgenerate

    logic [SIZE_IN-1:0] word_q, word_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full_q, full_d;

    logic out_xfer;
    logic last_slice;
    logic drain_done;
    logic in_xfer;

    // View the active word as an array of slices so the counter selects directly.
    logic [RATIO-1:0][SIZE_OUT-1:0] word_slices;

    assign word_slices = word_q;
    assign data_out    = word_slices[cnt_q];
    assign valid_out   = full_q;

    assign out_xfer   = full_q && ready_out;
    assign last_slice = (cnt_q == CNT_LAST);
    assign drain_done = out_xfer && last_slice;

`ifdef BUS_WIDTH_DECREASE_DOUBLE_BUF_EN
    logic [SIZE_IN-1:0] hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               ready_in_q;

    assign ready_in = ready_in_q;
    assign in_xfer  = valid_in && ready_in_q;

    // The hold register can only be occupied while the active word is full,
    // so an empty active register always loads straight from data_in.
    always_comb begin
        word_d      = word_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (!full_q) begin
            if (in_xfer) begin
                word_d = data_in;
                cnt_d  = '0;
                full_d = 1'b1;
            end
        end else if (drain_done) begin
            cnt_d = '0;
            if (hold_full_q) begin
                word_d      = hold_q;
                hold_full_d = 1'b0;
            end else if (in_xfer) begin
                word_d = data_in;
            end else begin
                full_d = 1'b0;
            end
        end else begin
            if (out_xfer) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (in_xfer) begin
                hold_d      = data_in;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q      <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_in_q  <= 1'b1;
        end else begin
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_in_q  <= !hold_full_d;
        end
    end
`else
    // A new word may load on the same edge that the last slice leaves.
    assign ready_in = !full_q || drain_done;
    assign in_xfer  = valid_in && ready_in;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (in_xfer) begin
            word_d = data_in;
            cnt_d  = '0;
            full_d = 1'b1;
        end else if (out_xfer) begin
            if (last_slice) begin
                cnt_d  = '0;
                full_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end
`endif

endmodule

// File: tb/tb_bus_width_decrease.sv
// Testbench for bus_width_decrease (SIZE_IN=32, SIZE_OUT=8).
// A queue of pending input words feeds the DUT; every accepted word is turned
// into its four LSB-first bytes in an expected-slice queue, and every output
// transfer is compared against the head of that queue.
module tb_bus_width_decrease;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_in;
    logic        valid_out;
    logic        ready_out;
    logic [7:0]  data_out;

    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;

    logic [31:0] pend_q[$];
    logic [7:0]  exp_q[$];
    logic        log_v[$];
    logic [7:0]  log_d[$];

    bus_width_decrease #(.SIZE_IN(32), .SIZE_OUT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs just after a rising edge, sample at the
    // falling edge, update the reference model, advance to the next edge.
    task automatic tick(input logic rout, input bit gaps);
        logic vin;
        logic acc;
        logic r0;
        vin       = (pend_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        valid_in  = vin;
        data_in   = vin ? pend_q[0] : $urandom;
        ready_out = rout;
        @(negedge clk);
        log_v.push_back(valid_out);
        log_d.push_back(data_out);
        acc = vin && ready_in;
        if (valid_out && rout) begin
            n_out++;
            if (exp_q.size() == 0) chk("extra_slice", exp_q.size(), 1);
            else chk("stream", data_out, exp_q.pop_front());
        end
`ifdef BUS_WIDTH_DECREASE_DOUBLE_BUF_EN
        r0        = ready_in;
        ready_out = !rout;
        #1;
        chk("ready_in_registered", ready_in, r0);
        ready_out = rout;
`else
        r0 = 1'b0;
`endif
        if (acc) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(8'((pend_q[0] >> (8 * k)) & 32'hFF));
            void'(pend_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        data_in   = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_ready_in", ready_in, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready_in", ready_in, 1);
        chk("post_rst_valid_out", valid_out, 0);

        // Single word, no back-pressure.
        log_v.delete(); log_d.delete();
        pend_q.push_back(32'hDDCC_BBAA);
        repeat (6) tick(1'b1, 1'b0);
        chk("w1_lat_v0", log_v[0], 0);
        chk("w1_s0", {log_v[1], log_d[1]}, {1'b1, 8'hAA});
        chk("w1_s1", {log_v[2], log_d[2]}, {1'b1, 8'hBB});
        chk("w1_s2", {log_v[3], log_d[3]}, {1'b1, 8'hCC});
        chk("w1_s3", {log_v[4], log_d[4]}, {1'b1, 8'hDD});
        chk("w1_after_v", log_v[5], 0);

        // Two words back-to-back: eight slices with no gap.
        log_v.delete(); log_d.delete();
        pend_q.push_back(32'h0302_0100);
        pend_q.push_back(32'h0706_0504);
        repeat (10) tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) chk($sformatf("b2b_s%0d", i), {log_v[1+i], log_d[1+i]}, {1'b1, 8'(i)});
        chk("b2b_after_v", log_v[9], 0);

        // Back-pressure at slice 1.
        log_v.delete(); log_d.delete();
        pend_q.push_back(32'h4433_2211);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b0);
        chk("bp_s0", log_d[1], 8'h11);
        for (int i = 2; i < 5; i++) chk($sformatf("bp_hold%0d", i), {log_v[i], log_d[i]}, {1'b1, 8'h22});
        chk("bp_s1", {log_v[5], log_d[5]}, {1'b1, 8'h22});
        chk("bp_s2", {log_v[6], log_d[6]}, {1'b1, 8'h33});
        chk("bp_s3", {log_v[7], log_d[7]}, {1'b1, 8'h44});
        chk("bp_after_v", log_v[8], 0);

        // Reset mid-word.
        pend_q.push_back(32'hDDCC_BBAA);
        repeat (3) tick(1'b1, 1'b0);
        chk("mid_pre_rst", {valid_out, data_out}, {1'b1, 8'hCC});
        valid_in = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("mid_rst_valid_out", valid_out, 0);
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_ready_in", ready_in, 1);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        log_v.delete(); log_d.delete();
        pend_q.push_back(32'h1234_5678);
        repeat (6) tick(1'b1, 1'b0);
        chk("after_rst_s0", {log_v[1], log_d[1]}, {1'b1, 8'h78});
        chk("after_rst_s3", {log_v[4], log_d[4]}, {1'b1, 8'h12});
        chk("after_rst_drained", exp_q.size(), 0);

        // Random words with random input gaps and random back-pressure.
        n_out = 0;
        for (int i = 0; i < 20; i++) pend_q.push_back($urandom);
        for (int c = 0; c < 800 && (pend_q.size() > 0 || exp_q.size() > 0); c++)
            tick($urandom_range(0, 3) != 0, 1'b1);
        chk("rand_pending_words", pend_q.size(), 0);
        chk("rand_pending_slices", exp_q.size(), 0);
        chk("rand_slice_count", n_out, 80);
        tick(1'b1, 1'b0);
        chk("rand_idle_valid", valid_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
